// File: rtl/axi_sram_rd_slave.sv
// rtl/axi_sram_rd_slave.sv - AXI4 single-burst read slave in front of a 256-bit SRAM
// Issues one SRAM read per beat, buffers returns in a 2-entry FIFO feeding the R channel.
`timescale 1ns/1ps
module axi_sram_rd_slave #(
  parameter int SRAM_AW = 10
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [6:0]         arid,
  input  logic [31:0]        araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic               arvalid,
  output logic               arready,
  output logic [6:0]         rid,
  output logic [255:0]       rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               o_sram_ce,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [255:0]       i_sram_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t             state_q;
  logic               arready_q;
  logic [6:0]         id_q;
  logic [7:0]         len_q;
  logic [1:0]         burst_q;
  logic [SRAM_AW-1:0] start_q;
  logic               err_q;
  logic [8:0]         issued_q;
  logic               inflight_q;
  logic               infl_last_q;
  logic [255:0]       fdata_q [2];
  logic [1:0]         fresp_q [2];
  logic               flast_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;

  logic               ar_hs;
  logic               ar_err;
  logic               pop;
  logic               issue;
  logic [2:0]         occ;
  logic [SRAM_AW-1:0] len_mask;
  logic [SRAM_AW-1:0] incr_addr;
  logic [SRAM_AW-1:0] issue_addr;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^araddr[4:0];
  assign ar_hs = arvalid && arready_q;
  assign ar_err = (arsize != 3'd5) || (arburst == 2'b11) || (|araddr[31:SRAM_AW+5]) ||
                  ((arburst == 2'b10) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign pop = (cnt_q != 2'd0) && rready;
  // Slots already committed (buffered or still coming back from SRAM), net of this cycle's pop.
  assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_BURST) && (issued_q < ({1'b0, len_q} + 9'd1)) && (occ < 3'd2);

  assign len_mask  = SRAM_AW'(len_q);
  assign incr_addr = start_q + SRAM_AW'(issued_q);
  always_comb begin
    issue_addr = incr_addr;
    case (burst_q)
      2'b00:   issue_addr = start_q;
      2'b10:   issue_addr = (start_q & ~len_mask) | (incr_addr & len_mask);
      default: issue_addr = incr_addr;
    endcase
  end

  assign o_sram_ce   = issue && !err_q;
  assign o_sram_addr = issue_addr;
  assign arready     = arready_q;
  assign rvalid      = (cnt_q != 2'd0);
  assign rdata       = fdata_q[rd_ptr_q];
  assign rresp       = fresp_q[rd_ptr_q];
  assign rlast       = flast_q[rd_ptr_q];
  assign rid         = id_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      start_q     <= '0;
      err_q       <= 1'b0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        fresp_q[i] <= '0;
        flast_q[i] <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            state_q   <= S_BURST;
            arready_q <= 1'b0;
            id_q      <= arid;
            len_q     <= arlen;
            burst_q   <= arburst;
            start_q   <= araddr[SRAM_AW+4:5];
            err_q     <= ar_err;
            issued_q  <= '0;
          end
        end
        default: begin
          if (pop && flast_q[rd_ptr_q]) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
          end
        end
      endcase

      if (issue) issued_q <= issued_q + 9'd1;
      inflight_q  <= issue;
      infl_last_q <= issue && (issued_q == {1'b0, len_q});

      // Error beats travel the same one-cycle pipe so beat timing is identical.
      if (inflight_q) begin
        fdata_q[wr_ptr_q] <= err_q ? '0 : i_sram_rdata;
        fresp_q[wr_ptr_q] <= err_q ? 2'b10 : 2'b00;
        flast_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
